// File: rtl/cachepool_l2_rd_arbiter.sv
// Round-robin read arbiter that shares one L2/DRAM AR+R channel among NumReq requesters.
// Requests pass through a one-entry AR register; R beats are routed back by the requester index held in the ID MSBs.
//
//   state | meaning
//   ------+-------------------------------------------------
//   EMPTY | AR stage holds nothing, mst_ar_valid_o low
//   FULL  | AR stage holds a granted request awaiting handshake
module cachepool_l2_rd_arbiter #(
    parameter int NumReq         = 4,
    parameter int AddrWidth      = 48,
    parameter int DataWidth      = 512,
    parameter int IdWidth        = 2,
    parameter int LenWidth       = 8,
    parameter int MaxOutstanding = 8,
    parameter int OutIdWidth     = IdWidth + $clog2(NumReq)
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic [NumReq-1:0]                                ar_valid_i,
    output logic [NumReq-1:0]                                ar_ready_o,
    input  logic [NumReq*AddrWidth-1:0]                      ar_addr_i,
    input  logic [NumReq*LenWidth-1:0]                       ar_len_i,
    input  logic [NumReq*IdWidth-1:0]                        ar_id_i,
    output logic [NumReq-1:0]                                r_valid_o,
    input  logic [NumReq-1:0]                                r_ready_i,
    output logic [DataWidth-1:0]                             r_data_o,
    output logic [IdWidth-1:0]                               r_id_o,
    output logic                                             r_last_o,
    output logic                                             mst_ar_valid_o,
    input  logic                                             mst_ar_ready_i,
    output logic [AddrWidth-1:0]                             mst_ar_addr_o,
    output logic [LenWidth-1:0]                              mst_ar_len_o,
    output logic [OutIdWidth-1:0]                            mst_ar_id_o,
    input  logic                                             mst_r_valid_i,
    output logic                                             mst_r_ready_o,
    input  logic [DataWidth-1:0]                             mst_r_data_i,
    input  logic [OutIdWidth-1:0]                            mst_r_id_i,
    input  logic                                             mst_r_last_i,
    output logic [NumReq*$clog2(MaxOutstanding+1)-1:0]       outstanding_o,
    output logic                                             busy_o
);

    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state_q;
    logic [IdxW-1:0]   rr_ptr_q;
    logic [CntW-1:0]   cnt_q [NumReq];

    logic [NumReq-1:0] eligible;
    logic              accept;
    logic              found;
    logic [IdxW-1:0]   grant_idx;
    logic [IdxW-1:0]   scan_idx;
    logic              grant_fire;
    logic [IdxW-1:0]   r_idx;
    logic              r_last_hs;
    logic [NumReq-1:0] inc;
    logic [NumReq-1:0] dec;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            eligible[i] = ar_valid_i[i] && (cnt_q[i] < MaxCnt);
        end
    end

    // A full stage can be refilled in the same cycle it hands off downstream.
    assign accept = (state_q == EMPTY) || mst_ar_ready_i;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < NumReq; i++) begin
            scan_idx = rr_ptr_q + IdxW'(i);
            if (!found && eligible[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign grant_fire = accept && found;

    always_comb begin
        ar_ready_o = '0;
        if (grant_fire) ar_ready_o[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= EMPTY;
            rr_ptr_q      <= '0;
            mst_ar_addr_o <= '0;
            mst_ar_len_o  <= '0;
            mst_ar_id_o   <= '0;
        end else begin
            if (grant_fire) begin
                mst_ar_addr_o <= ar_addr_i[grant_idx*AddrWidth +: AddrWidth];
                mst_ar_len_o  <= ar_len_i[grant_idx*LenWidth +: LenWidth];
                mst_ar_id_o   <= {grant_idx, ar_id_i[grant_idx*IdWidth +: IdWidth]};
                rr_ptr_q      <= grant_idx + IdxW'(1);
            end
            case (state_q)
                EMPTY: if (grant_fire) state_q <= FULL;
                FULL:  if (mst_ar_ready_i && !grant_fire) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign mst_ar_valid_o = (state_q == FULL);

    assign r_idx         = mst_r_id_i[OutIdWidth-1:IdWidth];
    assign mst_r_ready_o = r_ready_i[r_idx];
    assign r_data_o      = mst_r_data_i;
    assign r_id_o        = mst_r_id_i[IdWidth-1:0];
    assign r_last_o      = mst_r_last_i;
    assign r_last_hs     = mst_r_valid_i && mst_r_ready_o && mst_r_last_i;

    always_comb begin
        r_valid_o        = '0;
        r_valid_o[r_idx] = mst_r_valid_i;
    end

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            inc[i] = grant_fire && (grant_idx == IdxW'(i));
            dec[i] = r_last_hs && (r_idx == IdxW'(i)) && (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (inc[i] && !dec[i]) cnt_q[i] <= cnt_q[i] + CntW'(1);
                else if (dec[i] && !inc[i]) cnt_q[i] <= cnt_q[i] - CntW'(1);
            end
        end
    end

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_cnt
        assign outstanding_o[gi*CntW +: CntW] = cnt_q[gi];
        assert property (@(posedge clk_i) disable iff (rst_i) cnt_q[gi] <= MaxCnt);
    end

    always_comb begin
        busy_o = (state_q == FULL);
        for (int i = 0; i < NumReq; i++) begin
            if (cnt_q[i] != '0) busy_o = 1'b1;
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i)
        mst_ar_valid_o && !mst_ar_ready_i |=> rst_i ||
        (mst_ar_valid_o && $stable(mst_ar_addr_o) && $stable(mst_ar_len_o) && $stable(mst_ar_id_o)));

    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ar_ready_o));

    assert property (@(posedge clk_i) disable iff (rst_i) !(r_last_hs && cnt_q[r_idx] == '0));

endmodule

// File: tb/tb_cachepool_l2_rd_arbiter.sv
// Directed bench for cachepool_l2_rd_arbiter: grant order, backpressure, outstanding limits, R routing, async reset.
module tb_cachepool_l2_rd_arbiter;

    localparam int NumReq = 4;
    localparam int AW     = 48;
    localparam int DW     = 512;
    localparam int IW     = 2;
    localparam int LW     = 8;
    localparam int OIW    = 4;
    localparam int CW     = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [NumReq-1:0]    ar_valid_i = '0;
    logic [NumReq-1:0]    ar_ready_o;
    logic [NumReq*AW-1:0] ar_addr_i = '0;
    logic [NumReq*LW-1:0] ar_len_i = '0;
    logic [NumReq*IW-1:0] ar_id_i = '0;
    logic [NumReq-1:0]    r_valid_o;
    logic [NumReq-1:0]    r_ready_i = '0;
    logic [DW-1:0]        r_data_o;
    logic [IW-1:0]        r_id_o;
    logic                 r_last_o;
    logic                 mst_ar_valid_o;
    logic                 mst_ar_ready_i = 1'b0;
    logic [AW-1:0]        mst_ar_addr_o;
    logic [LW-1:0]        mst_ar_len_o;
    logic [OIW-1:0]       mst_ar_id_o;
    logic                 mst_r_valid_i = 1'b0;
    logic                 mst_r_ready_o;
    logic [DW-1:0]        mst_r_data_i = '0;
    logic [OIW-1:0]       mst_r_id_i = '0;
    logic                 mst_r_last_i = 1'b0;
    logic [NumReq*CW-1:0] outstanding_o;
    logic                 busy_o;

    int n_cmp = 0;
    int n_err = 0;

    cachepool_l2_rd_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i), .ar_id_i(ar_id_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .r_id_o(r_id_o), .r_last_o(r_last_o),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
        .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_len_o(mst_ar_len_o), .mst_ar_id_o(mst_ar_id_o),
        .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o), .mst_r_data_i(mst_r_data_i),
        .mst_r_id_i(mst_r_id_i), .mst_r_last_i(mst_r_last_i),
        .outstanding_o(outstanding_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        ar_valid_i     = '0;
        r_ready_i      = '0;
        mst_ar_ready_i = 1'b0;
        mst_r_valid_i  = 1'b0;
        mst_r_last_i   = 1'b0;
        mst_r_id_i     = '0;
        mst_r_data_i   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [IW-1:0] id);
        ar_addr_i[r*AW +: AW] = addr;
        ar_len_i[r*LW +: LW]  = len;
        ar_id_i[r*IW +: IW]   = id;
    endtask

    function automatic logic [CW-1:0] cnt(input int r);
        return outstanding_o[r*CW +: CW];
    endfunction

    initial begin
        do_reset();

        // 1: reset state, then a single burst from requester 2
        chk("rst_ar_valid", 64'(mst_ar_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_ar_addr", 64'(mst_ar_addr_o), 64'd0);
        set_req(2, 48'h0000_8000_0040, 8'd7, 2'd1);
        ar_valid_i = 4'b0100;
        #1 chk("t1_ar_ready", 64'(ar_ready_o), 64'h4);
        step();
        ar_valid_i = '0;
        chk("t1_mst_valid", 64'(mst_ar_valid_o), 64'd1);
        chk("t1_mst_addr", 64'(mst_ar_addr_o), 64'h8000_0040);
        chk("t1_mst_len", 64'(mst_ar_len_o), 64'd7);
        chk("t1_mst_id", 64'(mst_ar_id_o), 64'b1001);
        chk("t1_cnt2", 64'(cnt(2)), 64'd1);
        mst_ar_ready_i = 1'b1;
        step();
        mst_ar_ready_i = 1'b0;
        chk("t1_drained", 64'(mst_ar_valid_o), 64'd0);
        chk("t1_busy_inflight", 64'(busy_o), 64'd1);
        mst_r_valid_i = 1'b1;
        mst_r_id_i    = 4'b1001;
        #1 chk("t1_r_stall", 64'(mst_r_ready_o), 64'd0);
        chk("t1_r_valid_route", 64'(r_valid_o), 64'h4);
        r_ready_i = 4'b0100;
        for (int b = 0; b < 8; b++) begin
            mst_r_data_i = DW'(64'hA5A5_0000 + 64'(b));
            mst_r_last_i = (b == 7);
            #1;
            if (b == 0) begin
                chk("t1_r_ready", 64'(mst_r_ready_o), 64'd1);
                chk("t1_r_id", 64'(r_id_o), 64'd1);
            end
            if (b == 7) begin
                chk("t1_r_data", r_data_o[63:0], 64'hA5A5_0007);
                chk("t1_r_last", 64'(r_last_o), 64'd1);
                chk("t1_cnt_before_last", 64'(cnt(2)), 64'd1);
            end
            step();
        end
        idle_inputs();
        chk("t1_cnt_done", 64'(cnt(2)), 64'd0);
        chk("t1_busy_done", 64'(busy_o), 64'd0);

        // 2: round robin with all requesters active
        do_reset();
        for (int r = 0; r < NumReq; r++) set_req(r, AW'(64'h1000 * (r + 1)), LW'(r), IW'(r));
        ar_valid_i     = 4'b1111;
        mst_ar_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk("t2_ar_ready", 64'(ar_ready_o), 64'(1 << (i % 4)));
            step();
            chk("t2_mst_id", 64'(mst_ar_id_o), 64'(((i % 4) << 2) | (i % 4)));
            chk("t2_mst_addr", 64'(mst_ar_addr_o), 64'(64'h1000 * ((i % 4) + 1)));
        end
        ar_valid_i = '0;
        step();
        chk("t2_drained", 64'(mst_ar_valid_o), 64'd0);
        for (int r = 0; r < NumReq; r++) chk("t2_cnt", 64'(cnt(r)), 64'd2);

        // 3: downstream backpressure then release
        do_reset();
        set_req(1, 48'h0000_0000_1100, 8'd3, 2'd2);
        set_req(3, 48'h0000_0000_3300, 8'd5, 2'd3);
        ar_valid_i = 4'b1010;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_ar_ready_held", 64'(ar_ready_o), 64'd0);
            chk("t3_addr_stable", 64'(mst_ar_addr_o), 64'h1100);
            chk("t3_id_stable", 64'(mst_ar_id_o), 64'b0110);
            step();
        end
        chk("t3_valid_held", 64'(mst_ar_valid_o), 64'd1);
        mst_ar_ready_i = 1'b1;
        #1 chk("t3_release_grant", 64'(ar_ready_o), 64'h8);
        step();
        ar_valid_i = '0;
        chk("t3_next_id", 64'(mst_ar_id_o), 64'b1111);
        chk("t3_next_len", 64'(mst_ar_len_o), 64'd5);

        // 4: outstanding limit on requester 0
        do_reset();
        set_req(0, 48'h0000_0000_0A00, 8'd0, 2'd0);
        set_req(2, 48'h0000_0000_0C00, 8'd1, 2'd2);
        mst_ar_ready_i = 1'b1;
        ar_valid_i     = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            #1 chk("t4_fill_grant", 64'(ar_ready_o), 64'h1);
            step();
        end
        chk("t4_cnt_full", 64'(cnt(0)), 64'd8);
        chk("t4_masked", 64'(ar_ready_o), 64'd0);
        ar_valid_i = 4'b0101;
        #1 chk("t4_other_granted", 64'(ar_ready_o), 64'h4);
        step();
        ar_valid_i    = 4'b0001;
        mst_r_valid_i = 1'b1;
        mst_r_last_i  = 1'b1;
        mst_r_id_i    = 4'b0000;
        r_ready_i     = 4'b0001;
        #1 chk("t4_still_masked", 64'(ar_ready_o), 64'd0);
        step();
        mst_r_valid_i = 1'b0;
        mst_r_last_i  = 1'b0;
        r_ready_i     = '0;
        chk("t4_cnt_after_last", 64'(cnt(0)), 64'd7);
        chk("t4_reeligible", 64'(ar_ready_o), 64'h1);
        step();
        ar_valid_i = '0;
        chk("t4_cnt_refill", 64'(cnt(0)), 64'd8);

        // 5: increment and decrement of the same counter in one cycle
        do_reset();
        set_req(1, 48'h0000_0000_2200, 8'd0, 2'd1);
        mst_ar_ready_i = 1'b1;
        ar_valid_i     = 4'b0010;
        step();
        chk("t5_cnt1", 64'(cnt(1)), 64'd1);
        mst_r_valid_i = 1'b1;
        mst_r_last_i  = 1'b1;
        mst_r_id_i    = 4'b0101;
        r_ready_i     = 4'b0010;
        #1;
        chk("t5_grant", 64'(ar_ready_o), 64'h2);
        chk("t5_r_hs", 64'(mst_r_ready_o), 64'd1);
        step();
        idle_inputs();
        chk("t5_cnt_unchanged", 64'(cnt(1)), 64'd1);

        // 6: asynchronous reset mid-transaction
        do_reset();
        set_req(3, 48'h0000_0000_4400, 8'd2, 2'd0);
        ar_valid_i = 4'b1000;
        step();
        ar_valid_i = '0;
        chk("t6_pre_valid", 64'(mst_ar_valid_o), 64'd1);
        chk("t6_pre_cnt", 64'(cnt(3)), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_async_valid", 64'(mst_ar_valid_o), 64'd0);
        chk("t6_async_busy", 64'(busy_o), 64'd0);
        chk("t6_async_cnt", 64'(outstanding_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cachepool_l2_rd_arbiter.md
Name: cachepool_l2_rd_arbiter

Overview:
- Shares one L2/DRAM channel read path (AR + R) between NumReq cluster-side requesters.
- Sits between the cluster's per-port read masters and a single `axi_dram_sim` / L2 channel AR/R interface.
- Round-robin grant with a registered AR output stage.
- Per-requester outstanding-burst limiting.
- R beats are routed back by the requester index prefixed onto the downstream ID.

Parameters:
- NumReq, 4, number of requesters; power of two, at least 2.
- AddrWidth, 48, address width.
- DataWidth, 512, R data width.
- IdWidth, 2, per-requester ID width.
- LenWidth, 8, burst length field (AXI len, beats-1).
- MaxOutstanding, 8, maximum in-flight bursts per requester; at least 1.
- OutIdWidth, IdWidth+$clog2(NumReq), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- ar_valid_i  in  NumReq  per-requester AR valid.
- ar_ready_o  out  NumReq  per-requester AR ready.
- ar_addr_i  in  NumReq x AddrWidth  request address.
- ar_len_i  in  NumReq x LenWidth  burst length.
- ar_id_i  in  NumReq x IdWidth  local ID.
- r_valid_o  out  NumReq  routed R valid.
- r_ready_i  in  NumReq  R ready.
- r_data_o  out  DataWidth  R data, shared by all requesters; qualified by r_valid_o.
- r_id_o  out  IdWidth  local ID of the current beat.
- r_last_o  out  1  last beat.
- mst_ar_valid_o  out  1  downstream AR valid.
- mst_ar_ready_i  in  1  downstream AR ready.
- mst_ar_addr_o  out  AddrWidth  downstream address.
- mst_ar_len_o  out  LenWidth  downstream length.
- mst_ar_id_o  out  OutIdWidth  {requester index, local ID}.
- mst_r_valid_i  in  1  downstream R valid.
- mst_r_ready_o  out  1  downstream R ready.
- mst_r_data_i  in  DataWidth  downstream R data.
- mst_r_id_i  in  OutIdWidth  downstream R ID.
- mst_r_last_i  in  1  downstream R last.
- outstanding_o  out  NumReq x $clog2(MaxOutstanding+1)  per-requester in-flight burst count.
- busy_o  out  1  high when any outstanding count is nonzero or the AR stage is full.

Behaviour:

Reset (rst_i high, asynchronous):
- AR stage empty; mst_ar_valid_o=0; mst_ar_addr/len/id_o=0.
- All outstanding counters 0; RR pointer 0; busy_o=0.
- R path is combinational and holds no state.
- Reset asserted mid-transaction drops all in-flight state; no recovery of lost bursts is required.

AR stage, a one-entry register with states EMPTY and FULL:
- Eligible requester i: ar_valid_i[i]=1 and outstanding[i] < MaxOutstanding.
- Accept condition: stage EMPTY, or FULL with mst_ar_ready_i=1 in the same cycle (back-to-back, no bubble).
- On accept with at least one eligible requester: grant g is the first eligible index at or after the RR pointer, wrapping modulo NumReq.
  - ar_ready_o[g]=1 in that cycle; every other ar_ready_o bit is 0. ar_ready_o is never asserted for an ineligible requester.
  - Capture {g, ar_id_i[g]}, ar_addr_i[g], ar_len_i[g] into the stage.
  - Stage becomes (or stays) FULL; RR pointer <= (g+1) mod NumReq.
- FULL with mst_ar_ready_i=1 and nothing eligible: stage goes EMPTY.
- FULL with mst_ar_ready_i=0: contents held stable; all ar_ready_o=0.
- Latency: ar_valid_i→mst_ar_valid_o is 1 cycle. Sustained throughput is 1 AR/cycle.
- mst_ar_valid_o = FULL; it never deasserts without a handshake.

Outstanding counters:
- Increment outstanding[g] at upstream acceptance.
- Decrement outstanding[k] on an R handshake with mst_r_last_i=1, where k = mst_r_id_i[OutIdWidth-1:IdWidth].
- Increment and decrement on the same counter in the same cycle: net unchanged.
- A counter at MaxOutstanding masks that requester from eligibility until a last-beat decrement.
- Underflow (last beat arrives with count 0) is a protocol error: simulation assertion; the counter saturates at 0.

R routing, combinational:
- k = upper $clog2(NumReq) bits of mst_r_id_i.
- r_valid_o[k] = mst_r_valid_i; all other r_valid_o bits are 0.
- mst_r_ready_o = r_ready_i[k].
- r_data_o, r_last_o, r_id_o = mst_r_*; r_id_o takes the lower IdWidth bits.
- A stall on requester k blocks the shared R channel; interleaving is the downstream's responsibility.

Assertions:
- Stage contents stable while mst_ar_valid_o & !mst_ar_ready_i.
- ar_ready_o is onehot0.
- No counter overflow.

Test Plan:
1. Reset, then a single requester: req 2 issues addr 0x8000_0040, len 7, id 1 → mst_ar_valid_o 1 cycle later, mst_ar_id_o=0b1001, outstanding_o[2]=1. After 8 R beats with last, count 0 and busy_o=0.
2. Round robin: all 4 requesters hold ar_valid, mst_ar_ready_i always 1 → grant order 0,1,2,3,0,… with one AR per cycle and no bubbles.
3. Backpressure: mst_ar_ready_i=0 for 5 cycles with the stage FULL → mst_ar_* stable and ar_ready_o=0 throughout. Release → next grant is issued in the same cycle as the downstream handshake.
4. Outstanding limit: req 0 issues 8 bursts with R withheld → 9th request stalls and other requesters are still granted. One R last for req 0 → req 0 becomes eligible the next cycle.
5. Simultaneous increment/decrement: req 1 accepted in the same cycle that its R last beat handshakes → outstanding_o[1] unchanged.
6. Asynchronous reset asserted mid-burst with stage FULL and counts nonzero → mst_ar_valid_o, busy_o and outstanding_o are 0 immediately, without waiting for a clock edge.
